// File: rtl/schedule_fetch_sequencer.sv
// Resolves the active thermostat program instance for a time stamp by
// walking pattern -> week -> day -> instance through a 32-bit read port.
module schedule_fetch_sequencer #(
  parameter int G_ADDR_W = 10
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [5:0]          i_week_idx,
  input  logic [6:0]          i_day,
  input  logic [4:0]          i_hour,
  input  logic [5:0]          i_minute,
  output logic                o_mem_rd_en,
  output logic [G_ADDR_W-1:0] o_mem_addr,
  input  logic [31:0]         i_mem_rd_data,
  input  logic                i_mem_rd_valid,
  output logic                o_busy,
  output logic                o_done,
  output logic [31:0]         o_program_stc,
  output logic                o_program_error,
  output logic [2:0]          o_error_code
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHK,
    S_RD_PAT,
    S_RD_WK_LO,
    S_RD_WK_HI,
    S_RD_DAY_LO,
    S_RD_DAY_HI,
    S_SCAN,
    S_RD_SLOT,
    S_RD_HDR,
    S_FIN
  } t_state;

  localparam logic [2:0] C_PAT  = 3'd1;
  localparam logic [2:0] C_WEEK = 3'd2;
  localparam logic [2:0] C_DAY  = 3'd3;
  localparam logic [2:0] C_OVL  = 3'd4;
  localparam logic [2:0] C_INST = 3'd5;
  localparam logic [2:0] C_TIME = 3'd6;

  t_state r_state;
  t_state w_nxt;

  logic [5:0]          r_week;
  logic [6:0]          r_day;
  logic [4:0]          r_hour;
  logic [5:0]          r_min;
  logic [5:0]          r_pat_wk;
  logic [5:0]          r_day_idx;
  logic [31:0]         r_lo;
  logic [62:0]         r_mask;
  logic [5:0]          r_idx;
  logic                r_hit;
  logic [31:0]         r_hdr;
  logic [2:0]          r_code;
  logic                r_pend;
  logic                r_rd_en;
  logic [G_ADDR_W-1:0] r_addr;
  logic                r_busy;
  logic                r_done;
  logic [31:0]         r_stc;
  logic                r_perr;
  logic [2:0]          r_ecode;

  logic                w_issue;
  logic [G_ADDR_W-1:0] w_addr;
  logic                w_abort;
  logic [2:0]          w_acode;
  logic                w_rv;
  logic                w_start;
  logic                w_last;
  logic [1:0]          w_q;
  logic [6:0]          w_slot;
  logic [2:0]          w_k;
  logic [63:0]         w_wk64;
  logic [5:0]          w_wday;
  logic [6:0]          w_pat;
  logic                w_slot_bit;

  assign w_rv    = i_mem_rd_valid && r_pend;
  assign w_start = i_start && !r_done;
  assign w_last  = (r_idx == 6'd62);

  assign w_q = (r_min < 6'd15) ? 2'd0 :
               (r_min < 6'd30) ? 2'd1 :
               (r_min < 6'd45) ? 2'd2 : 2'd3;
  assign w_slot = {r_hour, 2'b00} + {5'd0, w_q};

  // lowest set day bit selects the week byte
  always_comb begin
    w_k = '0;
    for (int j = 6; j >= 0; j--)
      if (r_day[j]) w_k = 3'(j);
  end

  assign w_wk64     = {i_mem_rd_data, r_lo};
  assign w_wday     = w_wk64[{w_k, 3'b000} +: 6];
  assign w_pat      = i_mem_rd_data[{r_week[1:0], 3'b000} +: 7];
  assign w_slot_bit = i_mem_rd_data[w_slot[4:0]];

  always_comb begin
    w_nxt   = r_state;
    w_issue = 1'b0;
    w_addr  = '0;
    w_abort = 1'b0;
    w_acode = '0;
    unique case (r_state)
      S_IDLE: if (w_start) w_nxt = S_CHK;
      S_CHK: begin
        if (r_hour > 5'd23 || r_min > 6'd59) begin
          w_abort = 1'b1;
          w_acode = C_TIME;
        end else if (r_week > 6'd51) begin
          w_abort = 1'b1;
          w_acode = C_PAT;
        end else begin
          w_nxt   = S_RD_PAT;
          w_issue = 1'b1;
          w_addr  = G_ADDR_W'(512 + r_week[5:2]);
        end
      end
      S_RD_PAT: if (w_rv) begin
        if (!w_pat[6]) begin
          w_abort = 1'b1;
          w_acode = C_PAT;
        end else begin
          w_nxt   = S_RD_WK_LO;
          w_issue = 1'b1;
          w_addr  = G_ADDR_W'(384 + 2 * w_pat[5:0]);
        end
      end
      S_RD_WK_LO: if (w_rv) begin
        w_nxt   = S_RD_WK_HI;
        w_issue = 1'b1;
        w_addr  = G_ADDR_W'(385 + 2 * r_pat_wk);
      end
      S_RD_WK_HI: if (w_rv) begin
        if (!i_mem_rd_data[31]) begin
          w_abort = 1'b1;
          w_acode = C_WEEK;
        end else begin
          w_nxt   = S_RD_DAY_LO;
          w_issue = 1'b1;
          w_addr  = G_ADDR_W'(256 + 2 * w_wday);
        end
      end
      S_RD_DAY_LO: if (w_rv) begin
        w_nxt   = S_RD_DAY_HI;
        w_issue = 1'b1;
        w_addr  = G_ADDR_W'(257 + 2 * r_day_idx);
      end
      S_RD_DAY_HI: if (w_rv) begin
        if (!i_mem_rd_data[31]) begin
          w_abort = 1'b1;
          w_acode = C_DAY;
        end else begin
          w_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        if (r_mask[r_idx]) begin
          w_nxt   = S_RD_SLOT;
          w_issue = 1'b1;
          w_addr  = G_ADDR_W'({r_idx, w_slot[6:5]});
        end else if (w_last) begin
          w_nxt = S_FIN;
        end
      end
      S_RD_SLOT: if (w_rv) begin
        if (w_slot_bit) begin
          w_nxt   = S_RD_HDR;
          w_issue = 1'b1;
          w_addr  = G_ADDR_W'({r_idx, 2'b11});
        end else begin
          w_nxt = w_last ? S_FIN : S_SCAN;
        end
      end
      S_RD_HDR: if (w_rv) begin
        if (!i_mem_rd_data[31]) begin
          w_abort = 1'b1;
          w_acode = C_INST;
        end else if (r_hit) begin
          w_abort = 1'b1;
          w_acode = C_OVL;
        end else begin
          w_nxt = w_last ? S_FIN : S_SCAN;
        end
      end
      S_FIN: w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
    if (w_abort) w_nxt = S_FIN;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_week    <= '0;
      r_day     <= '0;
      r_hour    <= '0;
      r_min     <= '0;
      r_pat_wk  <= '0;
      r_day_idx <= '0;
      r_lo      <= '0;
      r_mask    <= '0;
      r_idx     <= '0;
      r_hit     <= 1'b0;
      r_hdr     <= '0;
      r_code    <= '0;
      r_pend    <= 1'b0;
      r_rd_en   <= 1'b0;
      r_addr    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_stc     <= '0;
      r_perr    <= 1'b0;
      r_ecode   <= '0;
    end else begin
      r_state <= w_nxt;
      r_rd_en <= w_issue;
      r_busy  <= (w_nxt != S_IDLE);
      r_done  <= (r_state == S_FIN);
      if (w_issue) r_addr <= w_addr;
      // a read return only counts against a strobe we issued
      if (w_issue) r_pend <= 1'b1;
      else if (w_rv) r_pend <= 1'b0;
      if (w_abort) r_code <= w_acode;
      unique case (r_state)
        S_IDLE: if (w_start) begin
          r_week <= i_week_idx;
          r_day  <= i_day;
          r_hour <= i_hour;
          r_min  <= i_minute;
          r_idx  <= '0;
          r_hit  <= 1'b0;
          r_hdr  <= '0;
          r_code <= '0;
        end
        S_RD_PAT:    if (w_rv) r_pat_wk <= w_pat[5:0];
        S_RD_WK_LO:  if (w_rv) r_lo <= i_mem_rd_data;
        S_RD_WK_HI:  if (w_rv) r_day_idx <= w_wday;
        S_RD_DAY_LO: if (w_rv) r_lo <= i_mem_rd_data;
        S_RD_DAY_HI: if (w_rv) r_mask <= {i_mem_rd_data[30:0], r_lo};
        S_SCAN:      if (!r_mask[r_idx]) r_idx <= r_idx + 6'd1;
        S_RD_SLOT:   if (w_rv && !w_slot_bit) r_idx <= r_idx + 6'd1;
        S_RD_HDR: if (w_rv) begin
          r_idx <= r_idx + 6'd1;
          if (i_mem_rd_data[31] && !r_hit) begin
            r_hit <= 1'b1;
            r_hdr <= i_mem_rd_data;
          end
        end
        S_FIN: begin
          r_perr  <= (r_code != 3'd0);
          r_ecode <= r_code;
          r_stc   <= (r_code == 3'd0 && r_hit) ? r_hdr : 32'd0;
        end
        default: ;
      endcase
    end
  end

  assign o_mem_rd_en     = r_rd_en;
  assign o_mem_addr      = r_addr;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_program_stc   = r_stc;
  assign o_program_error = r_perr;
  assign o_error_code    = r_ecode;

endmodule
